// File: rtl/result_stream_packer.sv
// result_stream_packer
//   Collects per-lane MAC result strobes into LANES-word groups and buffers
//   the groups in a FIFO. It then serialises each group onto an AXI4-Stream
//   master, lane 0 first, and frames every MATSIZE*MATSIZE words with tlast.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   lane_valid     per-lane one-cycle result strobe
//   lane_data      lane i result in bits [i*DATA_W +: DATA_W]
//   m_axis_tdata   output word (zero while tvalid is low)
//   m_axis_tvalid  output word valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   last word of each matrix
//   o_done         one-cycle pulse after the tlast beat is accepted
//   overflow       sticky: a strobe was dropped because its lane was still pending
//   fifo_level     groups currently held in the FIFO
module result_stream_packer #(
  parameter int unsigned MATSIZE    = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0]              lane_valid,
  input  logic [LANES*DATA_W-1:0]       lane_data,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          o_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned Words  = MATSIZE * MATSIZE;
  localparam int unsigned AddrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned BeatW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CntW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CntW-1:0]   LastWord  = CntW'(Words - 1);
  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(LANES - 1);
  localparam logic [LevelW-1:0] FullLevel = LevelW'(FIFO_DEPTH);

  typedef logic [LANES-1:0][DATA_W-1:0] group_t;

  group_t             lane_words;
  group_t             hold_q, hold_d;
  logic [LANES-1:0]   pending_q, pending_d;
  logic               overflow_q, overflow_d;
  group_t             mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]  level_q, level_d;
  logic [BeatW-1:0]   beat_q;
  logic [CntW-1:0]    word_q;
  logic               done_q;
  logic               full, empty, push, accept, pop;

  assign lane_words = lane_data;
  assign full       = (level_q == FullLevel);
  assign empty      = (level_q == '0);
  assign push       = (&pending_q) && !full;
  assign accept     = !empty && m_axis_tready;
  assign pop        = accept && (beat_q == LastBeat);

  // Capture: a push frees every lane this cycle, so a same-cycle strobe is
  // captured rather than counted as a drop.
  always_comb begin
    hold_d     = hold_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int i = 0; i < LANES; i++) begin
      if (push) pending_d[i] = 1'b0;
      if (lane_valid[i]) begin
        if (push || !pending_q[i]) begin
          hold_d[i]    = lane_words[i];
          pending_d[i] = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_q     <= '0;
      word_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      done_q     <= accept && (word_q == LastWord);
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (accept) begin
        beat_q <= pop ? '0 : beat_q + BeatW'(1);
        word_q <= (word_q == LastWord) ? '0 : word_q + CntW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= hold_q;
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q][beat_q];
  assign m_axis_tlast  = !empty && (word_q == LastWord);
  assign o_done        = done_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_result_stream_packer.sv
// Directed bench for result_stream_packer. A scoreboard queue holds expected
// output words, pushed when a group is completed by stimulus; a negedge
// monitor pops and compares on every accepted beat and models tlast/o_done.
module tb_result_stream_packer;
  localparam int MATSIZE    = 16;
  localparam int LANES      = 4;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int LAST       = MATSIZE * MATSIZE - 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [LANES-1:0]            lane_valid;
  logic [LANES*DATA_W-1:0]     lane_data;
  logic [DATA_W-1:0]           m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic                        o_done;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  result_stream_packer #(
    .MATSIZE(MATSIZE), .LANES(LANES), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_data(lane_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .o_done(o_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          tlast_pos[$];
  int          beats_seen = 0;
  int          done_count = 0;
  int          cnt = 0;
  bit          mon_en = 1'b0;
  bit          exp_done = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic [31:0] exp_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane l of the strobed lanes carries base+l.
  task automatic drive(input logic [3:0] mask, input logic [31:0] base);
    lane_valid = mask;
    for (int l = 0; l < LANES; l++)
      lane_data[l*DATA_W +: DATA_W] = mask[l] ? base + 32'(l) : $urandom();
  endtask

  task automatic idle();
    lane_valid = '0;
  endtask

  task automatic expect_group(input logic [31:0] base);
    for (int l = 0; l < LANES; l++) exp_q.push_back(base + 32'(l));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      lane_valid    = LANES'($urandom());
      lane_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_axis_tready = 1'($urandom());
      tick();
    end
    rst        = 1'b0;
    lane_valid = '0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(n >= budget), 64'(0));
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (rst) begin
        cnt      = 0;
        exp_done = 1'b0;
        held     = 1'b0;
      end else begin
        chk("o_done", 64'(o_done), 64'(exp_done));
        if (o_done) done_count++;
        if (held) begin
          chk("stall_valid", 64'(m_axis_tvalid), 64'(1));
          chk("stall_data", 64'(m_axis_tdata), 64'(held_data));
          chk("stall_last", 64'(m_axis_tlast), 64'(held_last));
        end
        exp_done = 1'b0;
        held     = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            chk("tdata", 64'(m_axis_tdata), 64'(exp_word));
          end
          chk("tlast", 64'(m_axis_tlast), 64'(cnt == LAST));
          if (m_axis_tlast) tlast_pos.push_back(beats_seen);
          exp_done = (cnt == LAST);
          cnt      = (cnt == LAST) ? 0 : cnt + 1;
          beats_seen++;
        end else if (m_axis_tvalid) begin
          held      = 1'b1;
          held_data = m_axis_tdata;
          held_last = m_axis_tlast;
        end
      end
    end
  end

  initial begin
    int base_beats;
    int base_done;
    lane_valid    = '0;
    lane_data     = '0;
    m_axis_tready = 1'b0;

    // Reset values with random inputs.
    do_reset(3);
    mon_en = 1'b1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_o_done", 64'(o_done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));

    // Single group, simultaneous strobes: tvalid two edges later.
    m_axis_tready = 1'b1;
    lane_valid = 4'b1111;
    lane_data  = {32'h44, 32'h33, 32'h22, 32'h11};
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    tick();
    idle();
    chk("lat_tvalid_n", 64'(m_axis_tvalid), 64'(0));
    tick();
    chk("lat_tvalid_n1", 64'(m_axis_tvalid), 64'(1));
    chk("lat_tdata_n1", 64'(m_axis_tdata), 64'(32'h11));
    drain("drain_single", 20);
    chk("single_level", 64'(fifo_level), 64'(0));

    // Staggered lanes, tready toggling 1010...
    base_beats = beats_seen;
    for (int c = 0; c < 40; c++) begin
      m_axis_tready = (c % 2 == 0);
      case (c)
        0: drive(4'b0001, 32'hA0);
        3: drive(4'b0010, 32'hA0);
        5: drive(4'b0100, 32'hA0);
        9: begin drive(4'b1000, 32'hA0); expect_group(32'hA0); end
        default: idle();
      endcase
      tick();
    end
    idle();
    m_axis_tready = 1'b1;
    drain("drain_stagger", 20);
    chk("stagger_beats", 64'(beats_seen - base_beats), 64'(4));

    // Two full matrices, paced one group per four cycles.
    do_reset(1);
    m_axis_tready = 1'b1;
    tlast_pos.delete();
    base_beats = beats_seen;
    base_done  = done_count;
    for (int g = 0; g < 2 * MATSIZE * MATSIZE / LANES; g++) begin
      drive(4'b1111, 32'h0100_0000 + 32'(g * LANES));
      expect_group(32'h0100_0000 + 32'(g * LANES));
      tick();
      idle();
      repeat (3) tick();
    end
    drain("drain_matrix", 40);
    repeat (2) tick();
    chk("matrix_beats", 64'(beats_seen - base_beats), 64'(512));
    chk("matrix_tlast_count", 64'(tlast_pos.size()), 64'(2));
    if (tlast_pos.size() == 2) begin
      chk("matrix_tlast0_pos", 64'(tlast_pos[0] - base_beats), 64'(255));
      chk("matrix_tlast1_pos", 64'(tlast_pos[1] - base_beats), 64'(511));
    end
    chk("matrix_done_count", 64'(done_count - base_done), 64'(2));

    // Overflow: fill 16 groups, hold a 17th, then a stray lane-0 strobe.
    m_axis_tready = 1'b0;
    base_beats = beats_seen;
    for (int g = 0; g < FIFO_DEPTH + 1; g++) begin
      drive(4'b1111, 32'h5000_0000 + 32'(g * LANES));
      expect_group(32'h5000_0000 + 32'(g * LANES));
      tick();
    end
    chk("ovf_level_full", 64'(fifo_level), 64'(FIFO_DEPTH));
    chk("ovf_before", 64'(overflow), 64'(0));
    drive(4'b0001, 32'hDEAD_BEEF);
    tick();
    idle();
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_level_hold", 64'(fifo_level), 64'(FIFO_DEPTH));
    tick();
    m_axis_tready = 1'b1;
    drain("drain_ovf", 120);
    chk("ovf_beats", 64'(beats_seen - base_beats), 64'(68));
    chk("ovf_sticky", 64'(overflow), 64'(1));

    // Lane-2 strobe on the push cycle lands in the next group.
    do_reset(1);
    m_axis_tready = 1'b1;
    drive(4'b1111, 32'hB0);
    expect_group(32'hB0);
    tick();
    drive(4'b0100, 32'hC0);
    tick();
    idle();
    tick();
    drive(4'b1011, 32'hC0);
    expect_group(32'hC0);
    tick();
    idle();
    drain("drain_simul", 20);
    chk("simul_no_ovf", 64'(overflow), 64'(0));

    // Reset while beat 2 of a group is presented.
    m_axis_tready = 1'b0;
    drive(4'b1111, 32'hD0);
    expect_group(32'hD0);
    tick();
    idle();
    repeat (2) tick();
    chk("mid_tvalid_up", 64'(m_axis_tvalid), 64'(1));
    m_axis_tready = 1'b1;
    repeat (2) tick();
    m_axis_tready = 1'b0;
    tick();
    chk("mid_beat2", 64'(m_axis_tdata), 64'(32'hD2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("mid_rst_level", 64'(fifo_level), 64'(0));
    m_axis_tready = 1'b1;
    drive(4'b1111, 32'hE0);
    expect_group(32'hE0);
    tick();
    idle();
    tick();
    chk("mid_restart_lane0", 64'(m_axis_tdata), 64'(32'hE0));
    drain("drain_restart", 20);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_stream_packer.md
# result_stream_packer

Downstream neighbour of the matrix-multiply controller. It collects the per-lane results that the four multiply-accumulate lanes signal with one-cycle strobes, groups them, buffers the groups in a FIFO, and serialises them onto an AXI4-Stream master port toward the DMA/PS. It also marks each matrix boundary with `tlast`, raises a completion pulse, and flags lost results.

## Interface
- `MATSIZE`, 16, matrix dimension; one matrix is MATSIZE*MATSIZE result words.
- `LANES`, 4, number of MAC lanes (the width of the strobe vector); MATSIZE*MATSIZE must be a multiple of LANES.
- `DATA_W`, 32, width of one result word.
- `FIFO_DEPTH`, 16, number of LANES-word groups buffered; must be a power of two.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lane_valid`  in  LANES  per-lane one-cycle result strobe.
- `lane_data`  in  LANES*DATA_W  lane i result in bits [i*DATA_W +: DATA_W]; valid only when the matching strobe is high.
- `m_axis_tdata`  out  DATA_W  output word.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  high on the last word of each matrix.
- `o_done`  out  1  one-cycle pulse at matrix completion.
- `overflow`  out  1  sticky flag: a result was dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  groups currently held in the FIFO.

## Operation
- **Capture stage**
  - Per-lane `pending[i]` bit and `hold[i]` register.
  - When `lane_valid[i]` is high and `pending[i]` is 0, load `hold[i]` from the lane's data and set `pending[i]`.
  - Lanes may strobe in any cycle and any order.
- **Group push**
  - When `pending` is all ones and the FIFO is not full, write {hold[LANES-1..0]} as one FIFO entry and clear all `pending` bits.
  - A strobe arriving in the same cycle as the push is captured: that lane's `pending` ends the cycle set with the new data.
- **Overflow**
  - A strobe on lane i while `pending[i]` is 1 and no push occurs that cycle is dropped. `hold[i]` is unchanged and `overflow` is set.
  - `overflow` clears only on `rst`.
  - If the FIFO is full, a complete group waits in the hold registers, and no data is lost until a further strobe arrives.
- **Serialiser**
  - The FIFO head is emitted as LANES beats, lane 0 first.
  - A beat index advances on each accepted beat (`tvalid && tready`).
  - On the accepted beat for lane LANES-1, the entry is popped and the index returns to 0.
- **Matrix framing**
  - Word counter 0..MATSIZE*MATSIZE-1 increments per accepted beat and wraps to 0.
  - `m_axis_tlast` is high exactly while the presented beat has count MATSIZE*MATSIZE-1.
- **o_done**: high for the single cycle after the tlast beat is accepted.
- **FIFO full/empty**
  - Push and pop in the same cycle is legal; the level is unchanged.
  - A push into a full FIFO never happens.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset**
  - All outputs are 0 one cycle after the `rst` edge.
  - Reset clears `pending`, the FIFO, the beat index, the word counter and `overflow`.
  - Reset mid-stream discards all buffered data; `tvalid` is low the cycle after.
- **Latency** (empty FIFO):
  - Edge N samples the completing strobe, and `pending` is full after edge N.
  - The push happens at edge N+1, and `m_axis_tvalid` with lane-0 data is high after edge N+1.
- **Throughput**: one beat per cycle while `tready` is high and the FIFO is non-empty, with no bubbles between groups.
- **AXI-Stream rules**
  - Once high, `tvalid` stays high, and `tdata`/`tlast` are held stable until accepted.
  - `tvalid` never depends combinationally on `tready`.
  - `tready` low for any duration loses no data.
- **Registering**: all outputs are registered or driven from FIFO storage/registers; there is no combinational path from inputs to outputs.
- **Arithmetic**: word counter width $clog2(MATSIZE*MATSIZE); beat index width $clog2(LANES).

## Test plan
- **Reset values**: assert `rst` 3 cycles with random inputs -> tvalid=0, tlast=0, o_done=0, overflow=0, fifo_level=0.
- **Single group, simultaneous strobes**: lane_valid=4'b1111 with data 0x11/0x22/0x33/0x44, tready=1 -> tvalid rises 2 edges later; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; fifo_level returns to 0.
- **Staggered lanes with backpressure**
  - Stimulus: lanes strobe on cycles 0, 3, 5, 9; tready toggles 1010...
  - Required: exactly four beats in lane order; tdata is stable through every tready=0 cycle.
- **Full matrix, then a second matrix**
  - Stimulus: 64 groups of incrementing data, tready=1.
  - Required: 256 beats in order; tlast only on beat 255; o_done pulses once, the cycle after; the second matrix's tlast is again on its beat 255.
- **Overflow**
  - Stimulus: tready=0; push 16 groups (fifo_level=16); complete a 17th group in `pending`; strobe lane 0 again.
  - Required: overflow=1 and lane-0 hold keeps its 17th-group value.
  - Then set tready=1 -> 68 beats, all of the first 17 groups, correct and in order.
- **Simultaneous push and capture, and reset mid-stream**
  - A lane-2 strobe on the push cycle appears in the next group with no overflow.
  - `rst` asserted during beat 2 of a group -> tvalid=0 after the reset edge; the next group starts at lane 0 with word count 0.
